// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, default widths,
// queue-entry layout and a saturating adder for the optional perf counters.
package if_pkg;

   localparam int IF_ADDR_W  = 32;
   localparam int IF_INSTR_W = 32;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [IF_ADDR_W-1:0]  pc;
      logic [IF_INSTR_W-1:0] instr;
   } if_entry_t;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous DEPTH-entry FIFO; push visible at head one cycle later, no bypass.
// Flush wins over push/pop; the caller must never push when full or pop when empty.
module if_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_dat_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_dat_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   // Storage needs no reset: count_q gates every read of it.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && push_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: up to DEPTH fetches in flight, response reaches ID one cycle later; freeze holds the head,
// issue stops when queued+in-flight reaches DEPTH, redirects flush and drain stale responses. IF_PERF_CNT_EN adds perf counters.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int                ADDR_W   = IF_ADDR_W,
   parameter int                INSTR_W  = IF_INSTR_W,
   parameter int                PC_STEP  = 1,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               if_valid,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [INSTR_W-1:0] if_instr
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_flushed,
   output logic [31:0]        perf_stall
`endif
);

   localparam int                CNT_W = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } q_entry_t;

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              init_q;

   logic [CNT_W-1:0]  q_count;
   logic              q_full, q_empty;
   logic              push, pop, req_acc;
   logic [CNT_W:0]    credit_used;
   q_entry_t          push_ent, head_ent;

   // init_q keeps requests off for the first cycle after reset.
   assign credit_used    = {1'b0, q_count} + {1'b0, outst_q};
   assign imem_req_valid = ~rst & ~init_q & (state_q == RUN) & ~branch_taken
                           & (credit_used < (CNT_W+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_acc        = imem_req_valid & imem_req_ready;

   assign push     = (state_q == RUN) & imem_rsp_valid & ~branch_taken;
   assign if_valid = ~rst & ~q_empty;
   assign pop      = if_valid & ~freeze & ~branch_taken;
   assign if_pc    = if_valid ? head_ent.pc    : '0;
   assign if_instr = if_valid ? head_ent.instr : '0;

   // rsp_pc_q tracks the fetch address of the oldest outstanding request.
   assign push_ent.pc    = rsp_pc_q + STEP;
   assign push_ent.instr = imem_rsp_data;

   always_comb begin
      outst_d    = outst_q + CNT_W'(req_acc) - CNT_W'(imem_rsp_valid);
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      if (branch_taken) begin
         fetch_pc_d = branch_addr;
         rsp_pc_d   = branch_addr;
      end else begin
         if (req_acc) fetch_pc_d = fetch_pc_q + STEP;
         if (push)    rsp_pc_d   = rsp_pc_q + STEP;
      end
      if (state_q == DRAIN)  drop_d = drop_q - CNT_W'(imem_rsp_valid);
      else if (branch_taken) drop_d = outst_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         init_q     <= 1'b1;
      end else begin
         init_q     <= 1'b0;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         case (state_q)
            RUN:     if (branch_taken && outst_d != '0) state_q <= DRAIN;
            DRAIN:   if (drop_d == '0) state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   if_fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + INSTR_W)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (branch_taken),
      .push_i     (push),
      .push_dat_i (push_ent),
      .pop_i      (pop),
      .head_dat_o (head_ent),
      .count_o    (q_count),
      .full_o     (q_full),
      .empty_o    (q_empty)
   );

   // Credit accounting must make this impossible.
   assert property (@(posedge clk) disable iff (rst) !(push && q_full));

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_flushed_q, perf_stall_q;
   logic [31:0] flush_inc;

   always_comb begin
      flush_inc = (branch_taken ? 32'(q_count) : 32'd0)
                + 32'(imem_rsp_valid & (branch_taken | (state_q == DRAIN)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= sat_add32(perf_fetched_q, 32'(push));
         perf_flushed_q <= sat_add32(perf_flushed_q, flush_inc);
         perf_stall_q   <= sat_add32(perf_stall_q, 32'(if_valid & freeze));
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a fixed-latency in-order memory model.
// Expected addresses/PCs are hand-derived from the cycle timelines of each scenario.
module tb_if_fetch_unit;
   import if_pkg::*;

   logic        clk = 1'b0;
   logic        rst, freeze, branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_pc, if_instr;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

   int total = 0;
   int bad   = 0;
   int mem_lat = 1;
   logic        pipe_v [4];
   logic [31:0] pipe_a [4];
   logic [31:0] req_log [$];
   if_entry_t   deq_log [$];

   if_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .branch_taken   (branch_taken),
      .branch_addr    (branch_addr),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed),
      .perf_stall     (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, advance the memory pipe after it.
   task automatic tick();
      logic        acc, was_rst;
      logic [31:0] acc_a;
      #1;
      acc     = imem_req_valid & imem_req_ready;
      acc_a   = imem_req_addr;
      was_rst = rst;
      if (acc) req_log.push_back(acc_a);
      if (if_valid & ~freeze & ~branch_taken) deq_log.push_back('{pc: if_pc, instr: if_instr});
      @(posedge clk);
      #1;
      for (int i = 3; i > 0; i--) begin
         pipe_v[i] = pipe_v[i-1];
         pipe_a[i] = pipe_a[i-1];
      end
      pipe_v[0] = acc;
      pipe_a[0] = acc_a;
      if (was_rst) begin
         for (int i = 0; i < 4; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 32'h0;
         end
      end
      imem_rsp_valid = pipe_v[mem_lat-1];
      imem_rsp_data  = pipe_v[mem_lat-1] ? instr_of(pipe_a[mem_lat-1]) : 32'h0;
   endtask

   task automatic do_reset(input int lat);
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; mem_lat = lat;
      tick();
      rst = 1'b0;
      tick();
      req_log.delete();
      deq_log.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      for (int i = 0; i < 4; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = 32'h0; end

      // 1: reset values, then back-to-back fetch with 1-cycle memory
      #1;
      check_eq("rst_req_valid", imem_req_valid, 0);
      check_eq("rst_if_valid", if_valid, 0);
      check_eq("rst_if_pc", if_pc, 0);
      check_eq("rst_if_instr", if_instr, 0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check_eq("post_rst_req_valid", imem_req_valid, 0);
      check_eq("post_rst_if_valid", if_valid, 0);
      check_eq("post_rst_if_pc", if_pc, 0);
      check_eq("post_rst_req_addr", imem_req_addr, 0);
      tick();
      req_log.delete(); deq_log.delete();
      repeat (12) tick();
      check_eq("t1_req_cnt", req_log.size(), 12);
      for (int i = 0; i < req_log.size(); i++) check_eq("t1_req_addr", req_log[i], i);
      check_eq("t1_deq_cnt", deq_log.size(), 10);
      for (int i = 0; i < deq_log.size(); i++) begin
         check_eq("t1_if_pc", deq_log[i].pc, i + 1);
         check_eq("t1_if_instr", deq_log[i].instr, instr_of(i));
      end

      // 2: freeze fills the queue, head held; release keeps order
      freeze = 1'b1;
      req_log.delete(); deq_log.delete();
      repeat (10) tick();
      check_eq("t2_req_valid_full", imem_req_valid, 0);
      check_eq("t2_if_valid_held", if_valid, 1);
      check_eq("t2_head_pc", if_pc, 11);
      check_eq("t2_head_instr", if_instr, instr_of(10));
      check_eq("t2_req_cnt_frozen", req_log.size(), 2);
      check_eq("t2_deq_cnt_frozen", deq_log.size(), 0);
      freeze = 1'b0;
      req_log.delete(); deq_log.delete();
      repeat (12) tick();
      check_eq("t2_deq_cnt_release", deq_log.size(), 12);
      for (int i = 0; i < deq_log.size(); i++) begin
         check_eq("t2_if_pc", deq_log[i].pc, 11 + i);
         check_eq("t2_if_instr", deq_log[i].instr, instr_of(10 + i));
      end

      // 3: latency 3, redirect with two fetches outstanding
      do_reset(3);
      tick(); tick();
      branch_taken = 1'b1; branch_addr = 32'h100;
      #1;
      check_eq("t3_no_issue_on_branch", imem_req_valid, 0);
      tick();
      branch_taken = 1'b0;
      #1;
      check_eq("t3_drain1_req_valid", imem_req_valid, 0);
      check_eq("t3_drain1_if_valid", if_valid, 0);
      tick();
      #1;
      check_eq("t3_drain2_req_valid", imem_req_valid, 0);
      tick();
      #1;
      check_eq("t3_run_req_valid", imem_req_valid, 1);
      check_eq("t3_run_req_addr", imem_req_addr, 32'h100);
      req_log.delete(); deq_log.delete();
      repeat (6) tick();
      check_eq("t3_first_req", req_log.size() > 0 ? req_log[0] : 32'hDEAD, 32'h100);
      check_eq("t3_deq_cnt", deq_log.size(), 2);
      if (deq_log.size() >= 2) begin
         check_eq("t3_first_pc", deq_log[0].pc, 32'h101);
         check_eq("t3_first_instr", deq_log[0].instr, instr_of(32'h100));
         check_eq("t3_second_pc", deq_log[1].pc, 32'h102);
      end

      // 4: branch with freeze and a response in the same cycle, then re-branch in DRAIN
      do_reset(3);
      freeze = 1'b1;
      repeat (4) tick();
      check_eq("t4_credit_stop", imem_req_valid, 0);
      check_eq("t4_pre_if_valid", if_valid, 1);
      check_eq("t4_pre_if_pc", if_pc, 1);
      check_eq("t4_pre_rsp_present", imem_rsp_valid, 1);
      branch_taken = 1'b1; branch_addr = 32'h200;
      tick();
      branch_addr = 32'h300;
      #1;
      check_eq("t4_flushed_if_valid", if_valid, 0);
      check_eq("t4_drain_req_valid", imem_req_valid, 0);
      tick();
      branch_taken = 1'b0;
      #1;
      check_eq("t4_drain2_req_valid", imem_req_valid, 0);
      tick();
      #1;
      check_eq("t4_run_req_valid", imem_req_valid, 1);
      check_eq("t4_run_req_addr", imem_req_addr, 32'h300);
`ifdef IF_PERF_CNT_EN
      check_eq("t4_perf_fetched", perf_fetched, 1);
      check_eq("t4_perf_flushed", perf_flushed, 4);
      check_eq("t4_perf_stall", perf_stall, 1);
`endif
      freeze = 1'b0;
      req_log.delete(); deq_log.delete();
      repeat (6) tick();
      check_eq("t4_first_req", req_log.size() > 0 ? req_log[0] : 32'hDEAD, 32'h300);
      check_eq("t4_deq_cnt", deq_log.size(), 2);
      if (deq_log.size() >= 1) check_eq("t4_first_pc", deq_log[0].pc, 32'h301);

      // 5: fetch address wraps at the top of the address space
      do_reset(1);
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
      tick();
      branch_taken = 1'b0;
      #1;
      check_eq("t5_req_valid", imem_req_valid, 1);
      check_eq("t5_req_addr", imem_req_addr, 32'hFFFF_FFFF);
      req_log.delete(); deq_log.delete();
      repeat (4) tick();
      check_eq("t5_req_cnt", req_log.size(), 4);
      if (req_log.size() >= 2) begin
         check_eq("t5_req0", req_log[0], 32'hFFFF_FFFF);
         check_eq("t5_req1_wrap", req_log[1], 32'h0);
      end
      check_eq("t5_deq_cnt", deq_log.size(), 2);
      if (deq_log.size() >= 2) begin
         check_eq("t5_if_pc_wrap", deq_log[0].pc, 32'h0);
         check_eq("t5_if_instr_wrap", deq_log[0].instr, instr_of(32'hFFFF_FFFF));
         check_eq("t5_if_pc_next", deq_log[1].pc, 32'h1);
      end

      // 6: reset in the middle of traffic
      do_reset(3);
      freeze = 1'b1;
      repeat (5) tick();
      check_eq("t6_pre_if_valid", if_valid, 1);
      check_eq("t6_pre_req_addr", imem_req_addr, 4);
`ifdef IF_PERF_CNT_EN
      check_eq("t6_pre_perf_fetched", perf_fetched, 2);
`endif
      rst = 1'b1;
      #1;
      check_eq("t6_in_rst_if_valid", if_valid, 0);
      check_eq("t6_in_rst_req_valid", imem_req_valid, 0);
      tick();
      rst = 1'b0; freeze = 1'b0;
      #1;
      check_eq("t6_after_if_valid", if_valid, 0);
      check_eq("t6_after_req_valid", imem_req_valid, 0);
      check_eq("t6_after_req_addr", imem_req_addr, 0);
      check_eq("t6_after_if_pc", if_pc, 0);
`ifdef IF_PERF_CNT_EN
      check_eq("t6_perf_fetched_clr", perf_fetched, 0);
      check_eq("t6_perf_flushed_clr", perf_flushed, 0);
      check_eq("t6_perf_stall_clr", perf_stall, 0);
`endif
      tick();
      #1;
      check_eq("t6_restart_req_valid", imem_req_valid, 1);
      check_eq("t6_restart_req_addr", imem_req_addr, 0);
      req_log.delete(); deq_log.delete();
      repeat (6) tick();
      check_eq("t6_deq_cnt", deq_log.size(), 2);
      if (deq_log.size() >= 1) check_eq("t6_first_pc", deq_log[0].pc, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
